// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - EX-stage MDU request and HI/LO/stall response bundle
interface muldiv_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_ID;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        md_stall;

  modport master (
    output start, op, A, B, md_ID,
    input  busy, HI, LO, md_stall
  );

  modport slave (
    input  start, op, A, B, md_ID,
    output busy, HI, LO, md_stall
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle mult/div controller owning HI/LO; optional MDU_DIVZERO_HOLD_EN
// keeps HI/LO unchanged on divide by zero.
module muldiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic          clk,
  input logic          reset,
  muldiv_ctrl_if.slave mdu
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [31:0] hi_p, lo_p, hi_r, lo_r;
  logic        hold_p;
  logic        is_mul, md_op, accept, commit, busy_w;

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] a_mag, b_mag, d_u, d_s, q_u, r_u, q_m, r_m;
  logic        b_nz;
  logic [31:0] res_hi, res_lo;
  logic        res_hold;

  assign is_mul = (mdu.op == OP_MULT) || (mdu.op == OP_MULTU);
  assign md_op  = mdu.start && (is_mul || (mdu.op == OP_DIV) || (mdu.op == OP_DIVU));

  // Result is computed when the op is accepted; the busy count only models latency.
  always_comb begin
    a_sx   = {{32{mdu.A[31]}}, mdu.A};
    b_sx   = {{32{mdu.B[31]}}, mdu.B};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, mdu.A} * {32'd0, mdu.B};
    a_mag  = mdu.A[31] ? (~mdu.A + 32'd1) : mdu.A;
    b_mag  = mdu.B[31] ? (~mdu.B + 32'd1) : mdu.B;
    b_nz   = (mdu.B != 32'd0);
    d_u    = b_nz ? mdu.B : 32'd1;
    d_s    = b_nz ? b_mag : 32'd1;
    q_u    = mdu.A / d_u;
    r_u    = mdu.A % d_u;
    q_m    = a_mag / d_s;
    r_m    = a_mag % d_s;
  end

  always_comb begin
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    res_hold = 1'b0;
    case (mdu.op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (!b_nz) begin
`ifdef MDU_DIVZERO_HOLD_EN
          res_hold = 1'b1;
`else
          res_hi = mdu.A;
          res_lo = 32'hFFFF_FFFF;
`endif
        end else if (mdu.op == OP_DIVU) begin
          res_hi = r_u;
          res_lo = q_u;
        end else begin
          // Sign-magnitude division: 8000_0000 / -1 wraps to 8000_0000 with no trap.
          res_lo = (mdu.A[31] ^ mdu.B[31]) ? (~q_m + 32'd1) : q_m;
          res_hi = mdu.A[31] ? (~r_m + 32'd1) : r_m;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (md_op) state_nx = RUN;
      RUN:     if (cnt <= 4'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_w       = (state == RUN);
    accept       = (state == IDLE) && md_op;
    commit       = (state == RUN) && (cnt <= 4'd1);
    mdu.busy     = busy_w;
    mdu.md_stall = mdu.md_ID && (busy_w || md_op);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= 4'd0;
      hi_p   <= 32'd0;
      lo_p   <= 32'd0;
      hold_p <= 1'b0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
    end else begin
      if (accept) begin
        cnt    <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        hi_p   <= res_hi;
        lo_p   <= res_lo;
        hold_p <= res_hold;
      end else if (state == RUN) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !hold_p) begin
        hi_r <= hi_p;
        lo_r <= lo_p;
      end
      if ((state == IDLE) && mdu.start && (mdu.op == OP_MTHI)) hi_r <= mdu.A;
      if ((state == IDLE) && mdu.start && (mdu.op == OP_MTLO)) lo_r <= mdu.A;
    end
  end

  assign mdu.HI = hi_r;
  assign mdu.LO = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl with directed and random MDU traffic
module tb_muldiv_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef struct {
    bit          is_md;
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } dir_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t        sbq[$];
  int          rem = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;
  logic        exp_busy = 1'b0;
  logic        exp_stall = 1'b0;
  logic        prev_busy = 1'b0;

  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk  (clk),
    .reset(reset),
    .mdu  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_calc(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      OP_MULT:  begin q = sa * sb; return q; end
      OP_MULTU: return ua * ub;
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
          return {hi, lo};
`else
          return {a, 32'hFFFF_FFFF};
`endif
        end
        if (o == OP_DIVU) return {a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {hi, lo};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rem > 0) rem--;
  endtask

  task automatic apply(input bit s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit mid, input bit use_exp, input logic [31:0] eh, input logic [31:0] el);
    logic [63:0] r;
    bit          md;
    int          n;
    bus.start = s;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    bus.md_ID = mid;
    md        = s && (o >= OP_MULT) && (o <= OP_DIVU);
    exp_busy  = (rem > 0);
    exp_stall = mid && (exp_busy || md);
    if (s && rem == 0) begin
      if (md) begin
        r = use_exp ? {eh, el} : ref_calc(o, a, b, model_hi, model_lo);
        model_hi = r[63:32];
        model_lo = r[31:0];
        n = (o <= OP_MULTU) ? MULT_N : DIV_N;
        sbq.push_back('{1'b1, cyc + 1 + n, model_hi, model_lo});
        rem = n + 1;
      end else if (o == OP_MTHI || o == OP_MTLO) begin
        if (o == OP_MTHI) model_hi = a;
        else              model_lo = a;
        if (use_exp) begin
          model_hi = eh;
          model_lo = el;
        end
        sbq.push_back('{1'b0, cyc + 1, model_hi, model_lo});
      end
    end
  endtask

  task automatic idle(input bit mid);
    apply(1'b0, 3'd0, 32'd0, 32'd0, mid, 1'b0, 32'd0, 32'd0);
  endtask

  // Monitor: pops an expectation when a multi-cycle op completes (busy falls) or an MT op is due.
  always @(negedge clk) begin
    exp_t e;
    bit   fell;
    if (reset) begin
      prev_busy = 1'b0;
    end else begin
      chk("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
      chk("md_stall", {31'd0, bus.md_stall}, {31'd0, exp_stall});
      fell = prev_busy && !bus.busy;
      if (sbq.size() > 0) begin
        e = sbq[0];
        if ((e.is_md && fell) || (!e.is_md && cyc == e.due)) begin
          void'(sbq.pop_front());
          chk("HI", bus.HI, e.hi);
          chk("LO", bus.LO, e.lo);
          chk("done_cycle", cyc, e.due);
        end else if (cyc > e.due + 1) begin
          void'(sbq.pop_front());
          chk("completion_timeout", cyc, e.due);
        end else if (fell) begin
          chk("unexpected_busy_fall", cyc, e.due);
        end
      end else if (fell) begin
        chk("busy_fall_with_empty_queue", 32'd1, 32'd0);
      end
      prev_busy = bus.busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    dir_t dirs[9];
    dirs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    dirs[1] = '{OP_MULTU, 32'hFFFF_FFFD, 32'd7,        32'h0000_0006, 32'hFFFF_FFEB};
    dirs[2] = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
    dirs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    dirs[4] = '{OP_MTLO,  32'h0000_1234, 32'd0,        32'hFFFF_FFFF, 32'h0000_1234};
    dirs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
    dirs[6] = '{OP_MTHI,  32'h0000_ABCD, 32'd0,        32'h0000_ABCD, 32'h8000_0000};
`ifdef MDU_DIVZERO_HOLD_EN
    dirs[7] = '{OP_DIV,   32'd5,         32'd0,        32'h0000_ABCD, 32'h8000_0000};
    dirs[8] = '{OP_DIVU,  32'd7,         32'd0,        32'h0000_ABCD, 32'h8000_0000};
`else
    dirs[7] = '{OP_DIV,   32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF};
    dirs[8] = '{OP_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF};
`endif

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    bus.md_ID = 1'b0;
    #12;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_stall", {31'd0, bus.md_stall}, 32'd0);
    chk("reset_HI", bus.HI, 32'd0);
    chk("reset_LO", bus.LO, 32'd0);
    #1 reset = 1'b0;

    // Directed: while busy, keep md_ID high and try an MTHI that must be ignored.
    foreach (dirs[i]) begin
      step();
      while (rem > 0) begin
        apply(1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
        step();
      end
      apply(1'b1, dirs[i].op, dirs[i].a, dirs[i].b, 1'b1, 1'b1, dirs[i].hi, dirs[i].lo);
    end
    while (rem > 0) begin
      step();
      idle(1'b0);
    end

    // Asynchronous reset mid-way through a DIV.
    step();
    apply(1'b1, OP_DIV, 32'd1000, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      idle(1'b0);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    sbq.delete();
    rem = 0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    exp_busy = 1'b0;
    exp_stall = 1'b0;
    #1;
    chk("midrun_reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrun_reset_HI", bus.HI, 32'd0);
    chk("midrun_reset_LO", bus.LO, 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    step();
    apply(1'b1, OP_MULT, 32'd6, 32'hFFFF_FFF9, 1'b1, 1'b0, 32'd0, 32'd0);

    // Random traffic, including starts while busy and divide by zero.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      step();
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 20);
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      apply($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), a, b,
            $urandom_range(0, 1) == 1, 1'b0, 32'd0, 32'd0);
    end

    for (int i = 0; i < DIV_N + 4; i++) begin
      step();
      idle(1'b0);
    end
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multiply/divide unit controller for the five-stage pipeline. It accepts MDU operations from the EX stage and runs multi-cycle mult/div with a busy counter. It owns the HI/LO architectural registers and raises the stall request the hazard logic uses to hold MDU-dependent instructions in ID. Its HI/LO read port is the source selected by the MEM-stage MDU forwarding path.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal 1..15)
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  EX-stage MDU operation valid this cycle
- op  input  3  EX-stage operation: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (no-op)
- A  input  32  EX-stage forwarded rs operand
- B  input  32  EX-stage forwarded rt operand
- md_ID  input  1  ID-stage instruction is any MDU instruction (mult/div/mthi/mtlo/mfhi/mflo)
- busy  output  1  multi-cycle operation in progress
- HI  output  32  HI register
- LO  output  32  LO register
- md_stall  output  1  stall request to hazard unit

## Operation
- States: IDLE, RUN. Down-counter cnt[3:0]; pending result regs hi_p, lo_p.
- IDLE, start=1, op in MULT/MULTU/DIV/DIVU: latch result into hi_p/lo_p, load cnt with MULT_CYCLES or DIV_CYCLES, go RUN.
- IDLE, start=1, op=MTHI: HI<=A. op=MTLO: LO<=A. Stay IDLE, busy stays 0.
- RUN: cnt decrements each edge. On the edge where cnt goes 1->0: HI<=hi_p, LO<=lo_p, go IDLE.
- Any start while RUN is ignored, including MTHI/MTLO. The hazard stall prevents this; the controller does not queue.
- op=000 or 111 with start=1: no effect.
- MULT: signed 32x32->64, {HI,LO}=product. MULTU: unsigned.
- DIV: LO=signed quotient truncated toward zero, HI=remainder with the sign of the dividend. DIVU: unsigned.
- DIV of 32'h80000000 by 32'hFFFFFFFF: LO=32'h80000000, HI=0 (no trap).
- Divide by zero: see Configuration.
- busy = (state==RUN).
- md_stall = md_ID & (busy | (start & op in MULT/MULTU/DIV/DIVU)). Combinational.

## Timing
- Reset values: busy=0, md_stall=0 (given md_ID=0), HI=0, LO=0, cnt=0, state IDLE. Reset asserted mid-RUN aborts immediately; the pending result is discarded.
- start sampled at edge k: busy=1 from after edge k through edge k+N, with N=MULT_CYCLES or DIV_CYCLES. HI/LO take the new value at edge k+N, the same edge busy falls.
- MTHI/MTLO latency: 1 edge. HI/LO read combinationally; a mfhi/mflo in EX after busy falls sees the new value.
- md_stall asserts in the same cycle as start, so the ID instruction behind a mult is held without a bubble gap. It deasserts in the cycle after the final RUN edge.
- Back-to-back: a start arriving in the cycle right after busy falls is accepted.

## Configuration
- MDU_DIVZERO_HOLD_EN defined: DIV/DIVU with B=0 still occupies DIV_CYCLES of busy, but HI and LO are left unchanged at completion.
- Undefined: DIV/DIVU with B=0 gives LO=32'hFFFFFFFF and HI=A at completion.

## Test plan
- MULT A=32'hFFFFFFFD, B=7, start at edge 0 -> busy high edges 1..5. At edge 5 HI=32'hFFFFFFFF, LO=32'hFFFFFFEB. MULTU with the same operands -> HI=6, LO=32'hFFFFFFEB.
- DIVU 100/7 -> after 10 cycles LO=14, HI=2. DIV A=32'hFFFFFFF9 (-7), B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- MTLO A=32'h1234 while idle -> LO=32'h1234 next edge, busy stays 0. MTHI issued during a DIV's RUN -> HI shows only the div remainder.
- md_ID=1 held while MULT starts -> md_stall=1 in the start cycle and for all 5 busy cycles, then 0 the next cycle. md_ID=0 -> md_stall never asserts.
- Reset pulse (asynchronous, mid-cycle) at cycle 4 of a DIV -> busy, HI and LO go to 0 immediately. A new MULT started after release completes normally.
- DIV 5/0 -> with MDU_DIVZERO_HOLD_EN, HI and LO keep their prior values. Without it, LO=32'hFFFFFFFF and HI=5. busy lasts 10 cycles in both cases.
